// File: rtl/alu_sequencer.sv
// Micro-sequencer running one 8-bit ALU operation per command over the main bus.
// Define ALU_SEQ_CHAIN_EN to let ADD/SUB/CMP reuse register A from the previous result.
module alu_sequencer #(
  parameter logic [2:0] IDLE_SEL        = 3'd7,
  parameter int         CHAIN_DEPTH_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_chain,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic [2:0] outctl,
  output logic [2:0] loadctl,
  output logic       alt,
  output logic       calcfn,
  input  logic [3:0] fin,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_flags,
  output logic [7:0] chain_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_CALC,
    S_PASSOUT,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_rsp_data;
  logic [3:0] r_rsp_flags;
  logic       w_accept;
  logic       w_chain_ok;
  logic       w_chain_take;
  logic [7:0] w_chain_cnt;

  assign cmd_ready    = (r_state == S_IDLE) & ~rst;
  assign w_accept     = cmd_valid & cmd_ready;
  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_data     = r_rsp_data;
  assign rsp_flags    = r_rsp_flags;
  assign chain_cnt    = w_chain_cnt;
  assign w_chain_take = w_chain_ok & cmd_chain & (cmd_op != OP_PASS);

`ifdef ALU_SEQ_CHAIN_EN
  localparam logic [7:0] CNT_MAX = 8'(CHAIN_DEPTH_MAX);

  logic       r_chain_ok;
  logic [7:0] r_chain_cnt;

  // A only holds a reusable result after an ADD/SUB write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain_ok  <= 1'b0;
      r_chain_cnt <= 8'd0;
    end else begin
      if (w_accept) begin
        if (!w_chain_take)
          r_chain_cnt <= 8'd0;
        else if (r_chain_cnt != CNT_MAX)
          r_chain_cnt <= r_chain_cnt + 8'd1;
      end
      if (r_state == S_CALC)
        r_chain_ok <= (r_op != OP_CMP);
      else if (r_state == S_PASSOUT)
        r_chain_ok <= 1'b0;
    end
  end

  assign w_chain_ok  = r_chain_ok;
  assign w_chain_cnt = r_chain_cnt;
`else
  logic [7:0] w_unused_cfg;

  assign w_unused_cfg = 8'(CHAIN_DEPTH_MAX);
  assign w_chain_ok   = 1'b0;
  assign w_chain_cnt  = 8'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_rsp_data  <= 8'd0;
      r_rsp_flags <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= cmd_op;
        r_a  <= cmd_a;
        r_b  <= cmd_b;
      end
      if (r_state == S_CALC || r_state == S_PASSOUT) begin
        r_rsp_data  <= bus_in;
        r_rsp_flags <= fin;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    outctl  = IDLE_SEL;
    loadctl = IDLE_SEL;
    bus_oe  = 1'b0;
    bus_out = 8'd0;
    alt     = 1'b0;
    calcfn  = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = w_chain_take ? S_LDB : S_LDA;
      end
      S_LDA: begin
        bus_oe  = 1'b1;
        bus_out = r_a;
        loadctl = 3'd0;
        w_next  = (r_op == OP_PASS) ? S_PASSOUT : S_LDB;
      end
      S_LDB: begin
        bus_oe  = 1'b1;
        bus_out = r_b;
        loadctl = 3'd1;
        w_next  = S_CALC;
      end
      S_CALC: begin
        outctl  = 3'd2;
        alt     = (r_op != OP_ADD);
        calcfn  = 1'b0;
        loadctl = (r_op == OP_CMP) ? IDLE_SEL : 3'd0;
        w_next  = S_RESP;
      end
      S_PASSOUT: begin
        outctl = 3'd0;
        w_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
